// File: rtl/bypass_scoreboard.sv
// Forwarding/hazard tracker: shift register of in-flight destination records that
// selects a bypass stage per source operand and raises a load-use style stall.
module bypass_scoreboard #(
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned SEL_W       = $clog2(NUM_STAGES + 1)
) (
    input  logic                                      clk,
    input  logic                                      rstN,
    input  logic                                      stall,
    input  logic                                      flush,
    input  logic                                      issueValid,
    input  logic                                      issueWEnable,
    input  logic [4:0]                                issueRdAddr,
    input  logic [((SEL_W > 1) ? SEL_W - 1 : 1)-1:0]  issueReadyStg,
    input  logic [NUM_SRC-1:0]                        srcUsed,
    input  logic [NUM_SRC*5-1:0]                      srcAddr,
    output logic [NUM_SRC*SEL_W-1:0]                  bypassSel,
    output logic                                      hazardStall,
    output logic [31:0]                               hazardCount
);

    localparam int unsigned RS_W  = (SEL_W > 1) ? SEL_W - 1 : 1;
    localparam int unsigned CNT_W = 32;

    logic [NUM_STAGES-1:0]  valid_q, valid_d;
    logic [4:0]             rd_q [NUM_STAGES];
    logic [4:0]             rd_d [NUM_STAGES];
    logic [RS_W-1:0]        rs_q [NUM_STAGES];
    logic [RS_W-1:0]        rs_d [NUM_STAGES];
    logic [CNT_W-1:0]       hazard_count_q, hazard_count_d;
    logic [NUM_SRC-1:0]     not_ready_c;
    logic                   issue_write_c;

    // Per-source lookup; scanning oldest to youngest lets the youngest match win.
    always_comb begin
        logic [SEL_W-1:0] sel;
        logic             nr;
        bypassSel   = '0;
        not_ready_c = '0;
        sel         = '0;
        nr          = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            sel = '0;
            nr  = 1'b0;
            if (srcUsed[k] && (srcAddr[k*5 +: 5] != 5'd0)) begin
                for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
                    if (valid_q[i] && (rd_q[i] == srcAddr[k*5 +: 5])) begin
                        if (32'(i) >= 32'(rs_q[i])) begin
                            sel = SEL_W'(i + 1);
                            nr  = 1'b0;
                        end else begin
                            sel = '0;
                            nr  = 1'b1;
                        end
                    end
                end
            end
            bypassSel[k*SEL_W +: SEL_W] = sel;
            not_ready_c[k]              = nr;
        end
    end

    assign hazardStall   = issueValid & (|not_ready_c);
    assign issue_write_c = issueValid & ~hazardStall & issueWEnable & (issueRdAddr != 5'd0);
    assign hazardCount   = hazard_count_q;

    // Next-state: flush beats stall beats shift; a flushed slot never takes the issue record.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            rd_d[i] = rd_q[i];
            rs_d[i] = rs_q[i];
        end
        if (!stall) begin
            for (int i = 1; i < int'(NUM_STAGES); i++) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
                rs_d[i]    = rs_q[i-1];
            end
            valid_d[0] = issue_write_c;
            rd_d[0]    = issueRdAddr;
            rs_d[0]    = issueReadyStg;
        end
        if (flush) begin
            for (int i = 0; i < int'(FLUSH_DEPTH); i++) begin
                valid_d[i] = 1'b0;
            end
        end
        hazard_count_d = hazard_count_q;
        if (hazardStall && (hazard_count_q != '1)) begin
            hazard_count_d = hazard_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q        <= '0;
            hazard_count_q <= '0;
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                rd_q[i] <= '0;
                rs_q[i] <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            hazard_count_q <= hazard_count_d;
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                rd_q[i] <= rd_d[i];
                rs_q[i] <= rs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Bench for bypass_scoreboard: directed scenarios plus randomized traffic against
// an age-based list model of in-flight producers.
module tb_bypass_scoreboard;

    localparam int NS = 2;
    localparam int FD = 1;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall, flush, issueValid, issueWEnable;
    logic [4:0]  issueRdAddr;
    logic [0:0]  issueReadyStg;
    logic [1:0]  srcUsed;
    logic [9:0]  srcAddr;
    logic [3:0]  bypassSel;
    logic        hazardStall;
    logic [31:0] hazardCount;

    int checks = 0;
    int errors = 0;

    bypass_scoreboard #(.NUM_STAGES(NS), .NUM_SRC(2), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .rstN(rstN), .stall(stall), .flush(flush),
        .issueValid(issueValid), .issueWEnable(issueWEnable),
        .issueRdAddr(issueRdAddr), .issueReadyStg(issueReadyStg),
        .srcUsed(srcUsed), .srcAddr(srcAddr),
        .bypassSel(bypassSel), .hazardStall(hazardStall), .hazardCount(hazardCount)
    );

    always #5 clk = ~clk;

    // Reference model: list of producers, each aged by the number of shifts since issue.
    typedef struct { logic [4:0] rd; int rs; int age; } rec_t;
    rec_t        mq[$];
    longint      m_count = 0;

    function automatic void m_lookup(input logic used, input logic [4:0] a,
                                     output int sel, output bit nr);
        int best = -1;
        int brs  = 0;
        sel = 0;
        nr  = 0;
        if (used && a != 5'd0) begin
            foreach (mq[j]) begin
                if (mq[j].rd == a && (best < 0 || mq[j].age < best)) begin
                    best = mq[j].age;
                    brs  = mq[j].rs;
                end
            end
            if (best >= 0) begin
                if (best >= brs) sel = best + 1;
                else nr = 1;
            end
        end
    endfunction

    function automatic bit m_hazard();
        int s0, s1;
        bit n0, n1;
        m_lookup(srcUsed[0], srcAddr[4:0], s0, n0);
        m_lookup(srcUsed[1], srcAddr[9:5], s1, n1);
        return issueValid && (n0 || n1);
    endfunction

    task automatic step();
        bit   hz;
        rec_t nq[$];
        hz = m_hazard();
        @(posedge clk);
        if (hz && m_count != 64'hFFFF_FFFF) m_count++;
        nq = {};
        foreach (mq[j]) begin
            rec_t r = mq[j];
            if (!stall) r.age++;
            if (r.age < NS && !(flush && r.age < FD)) nq.push_back(r);
        end
        if (!stall && !flush && issueValid && !hz && issueWEnable && issueRdAddr != 5'd0)
            nq.push_back('{rd: issueRdAddr, rs: int'(issueReadyStg), age: 0});
        mq = nq;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; issueValid = 0; issueWEnable = 0;
        issueRdAddr = 0; issueReadyStg = 0; srcUsed = 0; srcAddr = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic rs);
        issueValid = 1; issueWEnable = 1; issueRdAddr = rd; issueReadyStg = rs;
    endtask

    task automatic drain();
        idle();
        repeat (NS + 1) step();
    endtask

    task automatic test_reset();
        idle();
        rstN = 0;
        #12;
        rstN = 1;
        @(negedge clk); #1;
        checks++;
        if (bypassSel !== 4'd0 || hazardStall !== 1'b0 || hazardCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_init sel=%0h hz=%0b cnt=%0d exp 0/0/0", bypassSel, hazardStall, hazardCount);
        end
        // Build live state (including a hazard count) then reset mid-cycle.
        issue(5'd4, 1'b1); step();
        issueRdAddr = 5'd6; srcUsed = 2'b01; srcAddr = 10'd4; step();
        idle(); srcUsed = 2'b01; srcAddr = 10'd4; #1;
        checks++;
        if (bypassSel[1:0] !== 2'd2 || hazardCount !== 32'd1) begin
            errors++;
            $display("FAIL reset_prefill sel0=%0d cnt=%0d exp 2/1", bypassSel[1:0], hazardCount);
        end
        #1 rstN = 0;
        #1;
        checks++;
        if (bypassSel !== 4'd0 || hazardStall !== 1'b0 || hazardCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_async sel=%0h hz=%0b cnt=%0d exp 0/0/0", bypassSel, hazardStall, hazardCount);
        end
        mq = {};
        m_count = 0;
        @(negedge clk);
        rstN = 1;
        #1;
    endtask

    task automatic test_alu_chain();
        idle(); issue(5'd5, 1'b0); step();
        idle(); srcUsed = 2'b01; srcAddr = 10'd5; #1;
        checks++;
        if (bypassSel[1:0] !== 2'd1 || hazardStall !== 1'b0) begin
            errors++; $display("FAIL alu_e0 sel0=%0d hz=%0b exp 1/0", bypassSel[1:0], hazardStall);
        end
        step();
        checks++;
        if (bypassSel[1:0] !== 2'd2) begin
            errors++; $display("FAIL alu_e1 sel0=%0d exp 2", bypassSel[1:0]);
        end
        step();
        checks++;
        if (bypassSel[1:0] !== 2'd0) begin
            errors++; $display("FAIL alu_retired sel0=%0d exp 0", bypassSel[1:0]);
        end
        drain();
    endtask

    task automatic test_load_use();
        idle(); issue(5'd7, 1'b1); step();
        issue(5'd9, 1'b0); srcUsed = 2'b10; srcAddr = {5'd7, 5'd0}; #1;
        checks++;
        if (hazardStall !== 1'b1 || bypassSel[3:2] !== 2'd0) begin
            errors++; $display("FAIL load_use_stall hz=%0b sel1=%0d exp 1/0", hazardStall, bypassSel[3:2]);
        end
        step();
        checks++;
        if (hazardStall !== 1'b0 || bypassSel[3:2] !== 2'd2 || hazardCount !== 32'd1) begin
            errors++;
            $display("FAIL load_use_fwd hz=%0b sel1=%0d cnt=%0d exp 0/2/1", hazardStall, bypassSel[3:2], hazardCount);
        end
        step();
        idle(); srcUsed = 2'b01; srcAddr = 10'd9; #1;
        checks++;
        if (bypassSel[1:0] !== 2'd1) begin
            errors++; $display("FAIL load_use_reissue sel0=%0d exp 1", bypassSel[1:0]);
        end
        drain();
    endtask

    task automatic test_youngest();
        idle(); issue(5'd3, 1'b0); step();
        issue(5'd3, 1'b0); step();
        idle(); srcUsed = 2'b11; srcAddr = {5'd3, 5'd3}; #1;
        checks++;
        if (bypassSel !== 4'b0101) begin
            errors++; $display("FAIL youngest_ready sel=%0h exp 5", bypassSel);
        end
        drain();
        issue(5'd3, 1'b0); step();
        issue(5'd3, 1'b1); step();
        issue(5'd12, 1'b0); srcUsed = 2'b01; srcAddr = 10'd3; #1;
        checks++;
        if (bypassSel[1:0] !== 2'd0 || hazardStall !== 1'b1) begin
            errors++; $display("FAIL youngest_notready sel0=%0d hz=%0b exp 0/1", bypassSel[1:0], hazardStall);
        end
        drain();
        issue(5'd0, 1'b0); step();
        issue(5'd1, 1'b0); srcUsed = 2'b11; srcAddr = 10'd0; #1;
        checks++;
        if (bypassSel !== 4'd0 || hazardStall !== 1'b0) begin
            errors++; $display("FAIL x0_source sel=%0h hz=%0b exp 0/0", bypassSel, hazardStall);
        end
        drain();
    endtask

    task automatic test_flush_stall();
        idle(); issue(5'd10, 1'b0); step();
        issue(5'd11, 1'b0); step();
        issue(5'd12, 1'b0); stall = 1; srcUsed = 2'b11; srcAddr = {5'd10, 5'd11};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bypassSel !== 4'b1001) begin
                errors++; $display("FAIL stall_hold cyc=%0d sel=%0h exp 9", c, bypassSel);
            end
            step();
        end
        stall = 0; flush = 1; step();
        flush = 0; issueValid = 0; #1;
        checks++;
        if (bypassSel !== 4'b0010) begin
            errors++; $display("FAIL flush_shift sel=%0h exp 2", bypassSel);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int  s0, s1;
            bit  n0, n1;
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            issueValid    = $urandom_range(0, 1);
            issueWEnable  = ($urandom_range(0, 3) != 0);
            issueRdAddr   = 5'($urandom_range(0, 6));
            issueReadyStg = 1'($urandom_range(0, 1));
            srcUsed       = 2'($urandom_range(0, 3));
            srcAddr       = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
            #1;
            m_lookup(srcUsed[0], srcAddr[4:0], s0, n0);
            m_lookup(srcUsed[1], srcAddr[9:5], s1, n1);
            checks++;
            if (bypassSel !== {2'(s1), 2'(s0)} || hazardStall !== m_hazard()) begin
                errors++;
                $display("FAIL rand_lookup cyc=%0d sel=%0h hz=%0b exp sel=%0h hz=%0b",
                         c, bypassSel, hazardStall, {2'(s1), 2'(s0)}, m_hazard());
            end
            checks++;
            if (hazardCount !== 32'(m_count)) begin
                errors++; $display("FAIL rand_count cyc=%0d cnt=%0d exp %0d", c, hazardCount, m_count);
            end
            step();
        end
        drain();
    endtask

    task automatic test_saturation();
        idle(); issue(5'd7, 1'b1); step();
        idle();
        force dut.hazard_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.hazard_count_q;
        m_count = 64'hFFFF_FFFD;
        #1;
        issue(5'd8, 1'b0); stall = 1; srcUsed = 2'b01; srcAddr = 10'd7;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (hazardCount !== 32'(m_count)) begin
                errors++; $display("FAIL sat_count cyc=%0d cnt=%0h exp %0h", c, hazardCount, m_count);
            end
        end
        checks++;
        if (hazardCount !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_final cnt=%0h exp ffffffff", hazardCount);
        end
        drain();
    endtask

    initial begin
        idle();
        rstN = 1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest();
        test_flush_stall();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
